// File: rtl/soc_uart_ctrl.sv
// Buffered sequencer for one 8N1 UART core: TX FIFO feeds the core's start/empty
// handshake, RX FIFO drains received bytes with a registered ack, plus sticky errors.

module soc_uart_fifo #(
  parameter int AW = 3
) (
  input  logic          uclk,
  input  logic          res_n,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;

  // count never exceeds 2**AW, so its MSB alone marks full
  assign full  = count[AW];
  assign empty = (count == '0);
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge uclk or negedge res_n) begin
    if (!res_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge uclk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end
endmodule

module soc_uart_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  uclk,
  input  logic                  res_n,
  input  logic [7:0]            tx_wdata,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [7:0]            rx_rdata,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  err_overrun,
  output logic                  err_break,
  output logic                  err_txdrop,
  input  logic                  err_clr,
  output logic [7:0]            u_tx_data,
  output logic                  u_start_tx,
  input  logic                  u_tx_empty,
  input  logic                  u_rx_full,
  input  logic [7:0]            u_rx_data,
  input  logic                  u_rx_overrun,
  input  logic                  u_rx_break,
  output logic                  u_ack
);
  typedef enum logic [1:0] {T_IDLE, T_START, T_BUSY} tx_st_t;
  typedef enum logic [1:0] {R_WAIT, R_ACK} rx_st_t;

  tx_st_t     tx_st, tx_nxt;
  rx_st_t     rx_st, rx_nxt;
  logic       tx_pop, tx_fifo_empty;
  logic [7:0] tx_head, rx_head;
  logic       rx_push, rx_fifo_full;

  soc_uart_fifo #(.AW(DEPTH_LOG2)) u_tx_fifo (
    .uclk(uclk), .res_n(res_n), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_fifo_empty), .count(tx_count)
  );

  soc_uart_fifo #(.AW(DEPTH_LOG2)) u_rx_fifo (
    .uclk(uclk), .res_n(res_n), .wr(rx_push), .wdata(u_rx_data), .rd(rx_rd),
    .rdata(rx_head), .full(rx_fifo_full), .empty(rx_empty), .count(rx_count)
  );

  assign rx_rdata  = rx_empty ? 8'h00 : rx_head;
  // head cannot move while in T_START (only the pop advances rptr), so data is stable
  assign u_tx_data = (tx_st == T_START) ? tx_head : 8'h00;

  always_ff @(posedge uclk or negedge res_n) begin
    if (!res_n) begin
      tx_st <= T_IDLE;
      rx_st <= R_WAIT;
      u_ack <= 1'b0;
    end else begin
      tx_st <= tx_nxt;
      rx_st <= rx_nxt;
      u_ack <= (rx_nxt == R_ACK);
    end
  end

  // tx_empty is also high during the core's stop bit; holding start_tx until it
  // drops makes the core take the byte exactly when it becomes truly idle
  always_comb begin
    tx_nxt     = tx_st;
    u_start_tx = 1'b0;
    tx_pop     = 1'b0;
    case (tx_st)
      T_IDLE:  if (!tx_fifo_empty) tx_nxt = T_START;
      T_START: begin
        u_start_tx = 1'b1;
        if (!u_tx_empty) begin
          tx_pop = 1'b1;
          tx_nxt = T_BUSY;
        end
      end
      T_BUSY:  if (u_tx_empty) tx_nxt = T_IDLE;
      default: tx_nxt = T_IDLE;
    endcase
  end

  // rx_full is ignored in R_ACK: the core clears it on that edge, and a byte
  // landing on the same edge is still pending when R_WAIT resumes
  always_comb begin
    rx_nxt  = rx_st;
    rx_push = 1'b0;
    case (rx_st)
      R_WAIT: begin
        if (u_rx_full && !rx_fifo_full) begin
          rx_push = 1'b1;
          rx_nxt  = R_ACK;
        end else if (!u_rx_full && (u_rx_overrun || u_rx_break)) begin
          rx_nxt  = R_ACK;
        end
      end
      R_ACK:   rx_nxt = R_WAIT;
      default: rx_nxt = R_WAIT;
    endcase
  end

  // a set condition beats err_clr in the same cycle
  always_ff @(posedge uclk or negedge res_n) begin
    if (!res_n) begin
      err_overrun <= 1'b0;
      err_break   <= 1'b0;
      err_txdrop  <= 1'b0;
    end else begin
      if (u_rx_overrun)         err_overrun <= 1'b1;
      else if (err_clr)         err_overrun <= 1'b0;
      if (u_rx_break)           err_break   <= 1'b1;
      else if (err_clr)         err_break   <= 1'b0;
      if (tx_wr && tx_full)     err_txdrop  <= 1'b1;
      else if (err_clr)         err_txdrop  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_soc_uart_ctrl.sv
// Bench for soc_uart_ctrl: behavioural UART core (16 clk/bit), line decoder,
// queue-based RX model, directed sequence with randomized data bytes.
module tb_soc_uart_ctrl;
  localparam int DL  = 3;
  localparam int BIT = 16;

  logic uclk = 1'b0;
  logic res_n = 1'b0;
  always #5 uclk = ~uclk;

  logic [7:0]  tx_wdata = 8'h00;
  logic        tx_wr = 1'b0, rx_rd = 1'b0, err_clr = 1'b0;
  logic        tx_full, rx_empty, err_overrun, err_break, err_txdrop;
  logic [DL:0] tx_count, rx_count;
  logic [7:0]  rx_rdata, u_tx_data;
  logic        u_start_tx, u_tx_empty, u_ack;
  logic        u_rx_full = 1'b0, u_rx_overrun = 1'b0, u_rx_break = 1'b0;
  logic [7:0]  u_rx_data = 8'h00;

  soc_uart_ctrl #(.DEPTH_LOG2(DL)) dut (
    .uclk(uclk), .res_n(res_n), .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full),
    .tx_count(tx_count), .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_count(rx_count), .err_overrun(err_overrun), .err_break(err_break),
    .err_txdrop(err_txdrop), .err_clr(err_clr), .u_tx_data(u_tx_data),
    .u_start_tx(u_start_tx), .u_tx_empty(u_tx_empty), .u_rx_full(u_rx_full),
    .u_rx_data(u_rx_data), .u_rx_overrun(u_rx_overrun), .u_rx_break(u_rx_break),
    .u_ack(u_ack)
  );

  int passes = 0, total = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- core TX model: 0 idle, 1 start+data (tx_empty=0), 2 stop (tx_empty=1, no accept)
  int         ph = 0, cyc = 0, bitn = 0, accepts = 0;
  logic [8:0] sh = '0;
  logic       line = 1'b1, core_stall = 1'b0, stop_start_seen = 1'b0;
  assign u_tx_empty = (ph != 1);

  always @(posedge uclk) begin
    case (ph)
      0: if (u_start_tx && !core_stall) begin
           sh <= {u_tx_data, 1'b0}; line <= 1'b0; ph <= 1; cyc <= 0; bitn <= 0;
           accepts <= accepts + 1;
         end
      1: if (cyc == BIT-1) begin
           cyc <= 0;
           if (bitn == 8) begin line <= 1'b1; ph <= 2; end
           else begin bitn <= bitn + 1; line <= sh[bitn+1]; end
         end else cyc <= cyc + 1;
      default: begin
        if (u_start_tx) stop_start_seen <= 1'b1;
        if (cyc == BIT-1) begin cyc <= 0; ph <= 0; end
        else cyc <= cyc + 1;
      end
    endcase
  end

  // ---- line decoder: mid-bit sampling after each falling edge
  int         dstate = 0, dcyc = 0, dbit = 0, frame_err = 0;
  logic [7:0] dsh = '0;
  logic [7:0] line_q[$];
  always @(posedge uclk) begin
    if (dstate == 0) begin
      if (line == 1'b0) begin dstate <= 1; dcyc <= 0; dbit <= 0; end
    end else begin
      if (dcyc == BIT/2 + dbit*BIT) begin
        if (dbit == 0) begin
          if (line != 1'b0) dstate <= 0;
        end else if (dbit <= 8) dsh[dbit-1] <= line;
        else begin
          if (line) line_q.push_back(dsh);
          else frame_err <= frame_err + 1;
          dstate <= 0;
        end
        dbit <= dbit + 1;
      end
      dcyc <= dcyc + 1;
    end
  end

  // ---- core RX model: latest byte overwrites; arrival while still full flags overrun
  logic       rx_arrive = 1'b0, brk_req = 1'b0;
  logic [7:0] rx_arrive_data = 8'h00;
  int         acks = 0;
  always @(posedge uclk) begin
    if (u_ack) begin u_rx_full <= 1'b0; u_rx_overrun <= 1'b0; u_rx_break <= 1'b0; acks <= acks + 1; end
    if (rx_arrive) begin
      if (u_rx_full && !u_ack) u_rx_overrun <= 1'b1;
      u_rx_full <= 1'b1;
      u_rx_data <= rx_arrive_data;
    end
    if (brk_req) u_rx_break <= 1'b1;
  end

  logic [7:0] rx_model[$];

  task automatic tick(input int n);
    repeat (n) @(negedge uclk);
  endtask

  task automatic deliver(input logic [7:0] b);
    @(negedge uclk); rx_arrive = 1'b1; rx_arrive_data = b;
    @(negedge uclk); rx_arrive = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = rx_model.pop_front();
    check(tag, rx_rdata, e);
    rx_rd = 1'b1;
    @(negedge uclk); rx_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_tx[3];
    logic [7:0] first_b, b;
    int a0, n;
    exp_tx[0] = 8'h55; exp_tx[1] = 8'hA3; exp_tx[2] = 8'h00;

    tick(2);
    check("rst_tx_count", tx_count, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_rdata", rx_rdata, 0);
    check("rst_start_ack", {u_start_tx, u_ack}, 0);
    check("rst_u_tx_data", u_tx_data, 0);
    check("rst_err", {err_overrun, err_break, err_txdrop}, 0);
    res_n = 1'b1;

    // back-to-back TX
    @(negedge uclk); tx_wr = 1'b1; tx_wdata = exp_tx[0];
    @(negedge uclk); check("tx_lat1", u_start_tx, 0); tx_wdata = exp_tx[1];
    @(negedge uclk); check("tx_lat2", u_start_tx, 1); check("tx_data_hold", u_tx_data, 8'h55);
    tx_wdata = exp_tx[2];
    @(negedge uclk); tx_wr = 1'b0;
    check("tx_count3", tx_count, 3);
    n = 0;
    while (ph != 2 && n < 400) begin tick(1); n++; end
    tick(BIT/2);
    check("stop_start_hold", u_start_tx, 1);
    check("stop_no_dbl_pop", tx_count, 2);
    n = 0;
    while (!(line_q.size() == 3 && tx_count == 0 && ph == 0) && n < 2000) begin tick(1); n++; end
    check("tx_frames", line_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < line_q.size()) check("tx_byte", line_q[i], exp_tx[i]);
    check("tx_accepts", accepts, 3);
    check("tx_stop_seen", stop_start_seen, 1);
    check("tx_frame_err", frame_err, 0);
    check("tx_count0", tx_count, 0);

    // RX push and ack
    a0 = acks;
    deliver(8'h3C); rx_model.push_back(8'h3C);
    tick(1);
    check("rx_empty_fall", rx_empty, 0);
    check("rx_rdata", rx_rdata, 8'h3C);
    check("rx_ack_hi", u_ack, 1);
    check("rx_count1", rx_count, 1);
    tick(1);
    check("rx_ack_lo", u_ack, 0);
    check("rx_ack_once", acks, a0 + 1);
    pop_check("rx_pop1");
    check("rx_empty_again", rx_empty, 1);

    // RX backpressure
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      deliver(b); rx_model.push_back(b);
      tick(3);
    end
    check("rx_full8", rx_count, 8);
    a0 = acks;
    deliver(8'h99); tick(3);
    deliver(8'h77); tick(3);
    check("bp_no_ack", acks, a0);
    check("bp_overrun", err_overrun, 1);
    check("bp_count", rx_count, 8);
    pop_check("bp_pop");
    rx_model.push_back(8'h77);
    tick(3);
    check("bp_refill", rx_count, 8);
    check("bp_ack_once", acks, a0 + 1);
    for (int i = 0; i < 8; i++) pop_check("bp_drain");
    check("bp_empty", rx_empty, 1);

    // break
    a0 = acks;
    @(negedge uclk); brk_req = 1'b1;
    @(negedge uclk); brk_req = 1'b0;
    tick(3);
    check("brk_flag", err_break, 1);
    check("brk_ack", acks, a0 + 1);
    check("brk_fifo", rx_count, 0);
    @(negedge uclk); err_clr = 1'b1;
    @(negedge uclk); err_clr = 1'b0;
    check("clr_err", {err_overrun, err_break}, 0);

    // TX overflow with the core stalled
    core_stall = 1'b1;
    first_b = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge uclk); tx_wr = 1'b1; tx_wdata = 8'($urandom);
      if (i == 0) first_b = tx_wdata;
    end
    @(negedge uclk); tx_wr = 1'b0;
    check("ovf_count", tx_count, 8);
    check("ovf_full", tx_full, 1);
    check("ovf_drop", err_txdrop, 1);
    check("ovf_start", u_start_tx, 1);
    check("ovf_head", u_tx_data, first_b);
    @(negedge uclk); err_clr = 1'b1; tx_wr = 1'b1;
    @(negedge uclk); err_clr = 1'b0; tx_wr = 1'b0;
    check("clr_vs_set", err_txdrop, 1);
    @(negedge uclk); err_clr = 1'b1;
    @(negedge uclk); err_clr = 1'b0;
    check("clr_drop", err_txdrop, 0);
    @(negedge uclk); tx_wr = 1'b1;
    @(negedge uclk); tx_wr = 1'b0;
    check("drop_again", err_txdrop, 1);
    deliver(8'($urandom)); tick(2);
    check("pre_rst_rx", rx_count, 1);

    // reset mid-frame
    core_stall = 1'b0;
    tick(3 * BIT);
    check("mid_frame", tx_count, 7);
    #2 res_n = 1'b0;
    #1;
    check("arst_tx_count", tx_count, 0);
    check("arst_tx_full", tx_full, 0);
    check("arst_rx", {rx_empty, 3'(0), rx_count}, {1'b1, 3'(0), 4'(0)});
    check("arst_rx_rdata", rx_rdata, 0);
    check("arst_start_ack", {u_start_tx, u_ack}, 0);
    check("arst_u_tx_data", u_tx_data, 0);
    check("arst_err", {err_overrun, err_break, err_txdrop}, 0);
    tick(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/soc_uart_ctrl.md
# soc_uart_ctrl

Buffered controller that sequences one 8N1 UART core (`soc_uart`) on behalf of the SoC bus side. It feeds transmit bytes from a TX FIFO into the core's start/empty handshake and drains received bytes from the core into an RX FIFO, acknowledging each one. It also latches the core's overrun and break conditions into sticky error flags. The block sits between the peripheral register interface and `soc_uart`, and runs in the same `uclk` domain.

## Interface
- `DEPTH_LOG2`, default 3: each FIFO holds 2^DEPTH_LOG2 bytes (8 by default).
- `uclk`  in  1  clock; same clock as the UART core.
- `res_n`  in  1  reset, asynchronous, active-low.
- `tx_wdata`  in  8  byte to enqueue for transmission.
- `tx_wr`  in  1  enqueue `tx_wdata` this cycle.
- `tx_full`  out  1  TX FIFO full.
- `tx_count`  out  DEPTH_LOG2+1  TX FIFO occupancy.
- `rx_rdata`  out  8  RX FIFO head byte; valid while `rx_empty`=0.
- `rx_rd`  in  1  pop the RX FIFO head this cycle.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_count`  out  DEPTH_LOG2+1  RX FIFO occupancy.
- `err_overrun`  out  1  sticky: the core reported overrun.
- `err_break`  out  1  sticky: the core reported break.
- `err_txdrop`  out  1  sticky: a `tx_wr` arrived while the TX FIFO was full.
- `err_clr`  in  1  clears all three sticky flags.
- `u_tx_data`  out  8  to core `tx_data`.
- `u_start_tx`  out  1  to core `start_tx`.
- `u_tx_empty`  in  1  from core `tx_empty`.
- `u_rx_full`  in  1  from core `rx_full`.
- `u_rx_data`  in  8  from core `rx_data`.
- `u_rx_overrun`  in  1  from core `rx_overrun`.
- `u_rx_break`  in  1  from core `rx_break`.
- `u_ack`  out  1  to core `ack`; registered.

## Operation
- **Core behaviour the controller relies on:**
  - `tx_empty` is also high during the core's stop bit.
  - The core accepts `start_tx` only when it is truly idle.
- **FIFOs:** both are circular with DEPTH_LOG2-bit pointers that wrap modulo depth.
  - Write while full: dropped.
  - Read while empty: ignored.
  - Simultaneous read and write of a non-empty, non-full FIFO: count unchanged.
  - TX FIFO read while full, in the same cycle as a write: the write is dropped, because the full check uses the pre-edge state.
- **TX FSM:**
  - `T_IDLE`: if TX FIFO non-empty, go to `T_START`.
  - `T_START`: `u_start_tx`=1 combinationally; `u_tx_data` = TX head, held stable. On `u_tx_empty`=0, pop the TX head and go to `T_BUSY`. If the core is in its stop bit, `u_start_tx` stays high until the core goes idle and accepts.
  - `T_BUSY`: `u_start_tx`=0; on `u_tx_empty`=1, go to `T_IDLE`.
- **RX FSM:**
  - `R_WAIT`, core holds a byte: if `u_rx_full`=1 and the RX FIFO is not full, push `u_rx_data`, register `u_ack`=1, and go to `R_ACK`.
  - `R_WAIT`, status only: else if `u_rx_overrun` or `u_rx_break` is 1 (with no byte pending), register `u_ack`=1 and go to `R_ACK`.
  - `R_WAIT`, RX FIFO full: do not ack; the byte stays in the core (backpressure). Any further arrival raises the core's overrun.
  - `R_ACK`: `u_ack`=1 for exactly this cycle. Ignore `u_rx_full` here, since the core clears it on this edge. Return to `R_WAIT`.
  - A new byte completing on the ack edge leaves `u_rx_full`=1 with the new data. `R_WAIT` pushes it next cycle, so no byte is lost.
- **Sticky flags:**
  - `err_overrun` and `err_break` are set on any cycle where `u_rx_overrun` or `u_rx_break` respectively is 1.
  - `err_txdrop` is set on `tx_wr` while `tx_full`=1.
  - `err_clr` clears all three; a set condition in the same cycle wins.
- **Illegal FSM encodings:** return to `T_IDLE` / `R_WAIT`.

## Timing
- **Reset (async assert, sync deassert externally):**
  - Both FIFOs empty, pointers 0, `tx_count`=`rx_count`=0.
  - `tx_full`=0, `rx_empty`=1, `rx_rdata`=0.
  - `u_start_tx`=0, `u_ack`=0, `u_tx_data`=0.
  - All `err_*`=0; FSMs in `T_IDLE` / `R_WAIT`.
  - Reset mid-transfer discards both FIFOs. The core has its own reset and is not sequenced by this block.
- **TX latency:**
  - `tx_wr` to `u_start_tx` high: 2 cycles (FIFO write, then `T_IDLE`→`T_START`).
  - Pop occurs on the first cycle `u_tx_empty`=0 is observed.
- **RX latency:**
  - `u_rx_full` rising to `rx_empty`=0: 1 cycle.
  - `u_ack` pulse: 1 cycle wide, in the cycle after the push.
- `rx_rdata` and all status outputs reflect the current registered state; they are not pipelined.

## Test plan
- **Back-to-back TX:** write 0x55, 0xA3, 0x00 in consecutive cycles, with the core model at 16 `uclk` per bit. The line carries three 8N1 frames LSB-first with no bytes lost; `tx_count` reads 3→0; exactly three start handshakes occur.
- **Start during stop bit:** hold `u_tx_empty`=1 through the core's stop bit. `u_start_tx` stays high until the core accepts; the byte is popped once, not twice.
- **RX push and ack:** core delivers 0x3C. `rx_empty` falls 1 cycle later with `rx_rdata`=0x3C; `u_ack` is a single-cycle pulse; `rx_count`=1.
- **RX backpressure:** fill the RX FIFO with 8 bytes, then deliver 0x99 and 0x77 without `rx_rd`.
  - `u_ack` stays 0 and `err_overrun`=1.
  - After one `rx_rd`, 0x77 is pushed as the 8th entry.
- **Break:** the core asserts `u_rx_break`. `err_break`=1, one `u_ack` pulse, RX FIFO unchanged. Then `err_clr` returns it to 0.
- **TX overflow, reset mid-operation:** write 9 bytes into an 8-deep FIFO while the core is busy. Result: `err_txdrop`=1 and `tx_count`=8. Assert `res_n`=0 mid-frame: all outputs return to their reset values immediately.
